// File: rtl/alu_pipe_pkg.sv
//==============================================================================
// Module      : alu_pipe_pkg
// Description : Shared definitions for the handshaked pipelined ALU. Holds the
//               op-code enum, the bit positions of the flag bits and the
//               control FSM state encoding.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package alu_pipe_pkg;

  // Operation select codes carried on the op port
  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_NEG = 3'b001,
    OP_AND = 3'b010,
    OP_XOR = 3'b011,
    OP_SLL = 3'b100,
    OP_SRL = 3'b101,
    OP_SRA = 3'b110,
    OP_MUL = 3'b111
  } op_e;

  // Bit positions inside the 4-bit flags word {ovf, carry, neg, zero}
  localparam int FLG_ZERO  = 0;
  localparam int FLG_NEG   = 1;
  localparam int FLG_CARRY = 2;
  localparam int FLG_OVF   = 3;

  // Control FSM; MUL and DONE are only reachable with the multiplier built in
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

`default_nettype wire

// File: rtl/alu_pipe_if.sv
//==============================================================================
// Module      : alu_pipe_if
// Description : Operand/result handshake bundle for alu_pipe.
//   in_valid/in_ready : operand-side handshake (op, a, b)
//   out_valid/out_ready: result-side handshake (result, flags, out_err)
//   master modport: producer of operands / consumer of results
//   slave  modport: the ALU itself
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

interface alu_pipe_if #(
  parameter int WIDTH = 32
);

  logic             in_valid;
  logic             in_ready;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic [3:0]       flags;
  logic             out_err;

  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, result, flags, out_err
  );

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, result, flags, out_err
  );

endinterface

`default_nettype wire

// File: rtl/alu_mul_iter.sv
//==============================================================================
// Module      : alu_mul_iter
// Description : Unsigned shift-add multiplier, one multiplier bit per clock.
//               Only instantiated when ALU_PIPE_MUL_EN is defined.
//   clk, rst_n : clock / asynchronous active-low reset (aborts a multiply)
//   start      : load operands a, b and begin WIDTH iterations
//   last       : high on the cycle whose edge performs the final iteration
//   product    : full 2*WIDTH-bit product, stable once iterations finish
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module alu_mul_iter #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 last,
  output logic [2*WIDTH-1:0]   product
);

  localparam int CW = $clog2(WIDTH);

  logic                 busy_q,   busy_d;
  logic [CW-1:0]        cnt_q,    cnt_d;
  logic [WIDTH-1:0]     mplier_q, mplier_d;
  logic [2*WIDTH-1:0]   mcand_q,  mcand_d;
  logic [2*WIDTH-1:0]   acc_q,    acc_d;

  always_comb begin
    busy_d   = busy_q;
    cnt_d    = cnt_q;
    mplier_d = mplier_q;
    mcand_d  = mcand_q;
    acc_d    = acc_q;
    if (start) begin
      busy_d   = 1'b1;
      cnt_d    = '0;
      mplier_d = b;
      mcand_d  = {{WIDTH{1'b0}}, a};
      acc_d    = '0;
    end else if (busy_q) begin
      // Add the multiplicand aligned to the current multiplier bit
      if (mplier_q[0]) begin
        acc_d = acc_q + mcand_q;
      end
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + 1'b1;
      if (cnt_q == CW'(WIDTH - 1)) begin
        busy_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q   <= 1'b0;
      cnt_q    <= '0;
      mplier_q <= '0;
      mcand_q  <= '0;
      acc_q    <= '0;
    end else begin
      busy_q   <= busy_d;
      cnt_q    <= cnt_d;
      mplier_q <= mplier_d;
      mcand_q  <= mcand_d;
      acc_q    <= acc_d;
    end
  end

  assign last    = busy_q & (cnt_q == CW'(WIDTH - 1));
  assign product = acc_q;

endmodule

`default_nettype wire

// File: rtl/alu_pipe.sv
//==============================================================================
// Module      : alu_pipe
// Description : Handshaked ALU for the execute stage. Single-cycle ops
//               (ADD, NEG, AND, XOR, SLL, SRL, SRA) register result and flags
//               at the accepting edge. Build macro ALU_PIPE_MUL_EN adds an
//               iterative unsigned multiplier on op 111; without it op 111
//               returns result 0, flags 0001 and out_err=1.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset, released synchronously
//   bus   : alu_pipe_if slave (in_valid/in_ready/op/a/b,
//           out_valid/out_ready/result/flags/out_err)
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module alu_pipe
  import alu_pipe_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic      clk,
  input  logic      rst_n,
  alu_pipe_if.slave bus
);

  localparam int SHW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  state_e           state_q, state_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [3:0]       flags_q, flags_d;
  logic             out_err_q, out_err_d;
  logic             rdy_en_q, rdy_en_d;

  logic             accept;
  logic [SHW-1:0]   sh;
  logic [WIDTH:0]   add_w;
  logic [WIDTH:0]   sll_w;
  logic [WIDTH:0]   srl_w;
  logic [WIDTH:0]   sra_w;
  logic [WIDTH-1:0] alu_res;
  logic             alu_carry;
  logic             alu_ovf;
  logic             alu_err;
  logic [3:0]       alu_flags;

  // in_ready stays low until the first edge after reset release
  assign bus.in_ready = rdy_en_q & (state_q == ST_IDLE) &
                        (~out_valid_q | bus.out_ready);
  assign accept       = bus.in_valid & bus.in_ready;
  assign sh           = bus.b[SHW-1:0];

  // Shifts use one extra bit so the last bit shifted out lands in a fixed
  // position; with a zero amount that extra bit is the inserted zero.
  assign add_w = {1'b0, bus.a} + {1'b0, bus.b};
  assign sll_w = {1'b0, bus.a} << sh;
  assign srl_w = {bus.a, 1'b0} >> sh;
  assign sra_w = $signed({bus.a, 1'b0}) >>> sh;

  always_comb begin
    alu_res   = '0;
    alu_carry = 1'b0;
    alu_ovf   = 1'b0;
    alu_err   = 1'b0;
    case (bus.op)
      OP_ADD: begin
        alu_res   = add_w[WIDTH-1:0];
        alu_carry = add_w[WIDTH];
        alu_ovf   = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) &
                    (add_w[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OP_NEG: begin
        alu_res   = ~bus.b + 1'b1;
        alu_carry = (bus.b == '0);
        alu_ovf   = (bus.b == MIN_NEG);
      end
      OP_AND: alu_res = bus.a & bus.b;
      OP_XOR: alu_res = bus.a ^ bus.b;
      OP_SLL: begin
        alu_res   = sll_w[WIDTH-1:0];
        alu_carry = sll_w[WIDTH];
      end
      OP_SRL: begin
        alu_res   = srl_w[WIDTH:1];
        alu_carry = srl_w[0];
      end
      OP_SRA: begin
        alu_res   = sra_w[WIDTH:1];
        alu_carry = sra_w[0];
      end
      OP_MUL: begin
`ifdef ALU_PIPE_MUL_EN
        // Handled by the iterative multiplier; never registered from here
        alu_res = '0;
`else
        alu_err = 1'b1;
`endif
      end
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    alu_flags            = '0;
    alu_flags[FLG_ZERO]  = (alu_res == '0);
    alu_flags[FLG_NEG]   = alu_res[WIDTH-1];
    alu_flags[FLG_CARRY] = alu_carry;
    alu_flags[FLG_OVF]   = alu_ovf;
  end

`ifdef ALU_PIPE_MUL_EN
  logic                 mul_start;
  logic                 mul_last;
  logic [2*WIDTH-1:0]   mul_product;

  alu_mul_iter #(
    .WIDTH (WIDTH)
  ) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (mul_start),
    .a       (bus.a),
    .b       (bus.b),
    .last    (mul_last),
    .product (mul_product)
  );

  assign mul_start = accept & (bus.op == OP_MUL);
`endif

  always_comb begin
    state_d     = state_q;
    // A delivered result drops out_valid unless replaced below
    out_valid_d = out_valid_q & ~bus.out_ready;
    result_d    = result_q;
    flags_d     = flags_q;
    out_err_d   = out_err_q;
    rdy_en_d    = 1'b1;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
`ifdef ALU_PIPE_MUL_EN
          if (bus.op == OP_MUL) begin
            state_d = ST_MUL;
          end else begin
            out_valid_d = 1'b1;
            result_d    = alu_res;
            flags_d     = alu_flags;
            out_err_d   = alu_err;
          end
`else
          out_valid_d = 1'b1;
          result_d    = alu_res;
          flags_d     = alu_flags;
          out_err_d   = alu_err;
`endif
        end
      end
`ifdef ALU_PIPE_MUL_EN
      ST_MUL: begin
        if (mul_last) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        out_valid_d          = 1'b1;
        result_d             = mul_product[WIDTH-1:0];
        flags_d              = '0;
        flags_d[FLG_ZERO]    = (mul_product[WIDTH-1:0] == '0);
        flags_d[FLG_NEG]     = mul_product[WIDTH-1];
        flags_d[FLG_CARRY]   = |mul_product[2*WIDTH-1:WIDTH];
        out_err_d            = 1'b0;
        state_d              = ST_IDLE;
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      flags_q     <= '0;
      out_err_q   <= 1'b0;
      rdy_en_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      flags_q     <= flags_d;
      out_err_q   <= out_err_d;
      rdy_en_q    <= rdy_en_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.flags     = flags_q;
  assign bus.out_err   = out_err_q;

endmodule

`default_nettype wire

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
- Parametrised, handshaked successor to the single-cycle combinational ALU in the KGP-RISC datapath.
- Executes one operation per transaction on WIDTH-bit operands and registers result plus flags.
- Valid/ready on both sides, so the execute stage can stall and a multi-cycle multiplier can be added.
- Sits between register-file read and writeback in the core.

Parameters:
- WIDTH, 32: operand/result width; power of two, 8..64.
- SHW, $clog2(WIDTH): shift-amount width; derived, not overridden.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operands and op valid
- in_ready  out  1  block can accept this cycle
- op  in  3  operation select
- a  in  WIDTH  operand 1
- b  in  WIDTH  operand 2 / shift amount
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- result  out  WIDTH  registered result
- flags  out  4  {ovf, carry, neg, zero}, registered with result
- out_err  out  1  op not supported in this build

Behaviour:
- Reset: asynchronous on rst_n low; state applies immediately and is released synchronously to clk.
  - out_valid=0, result=0, flags=0, out_err=0, FSM=IDLE.
  - in_ready=1 from the first edge after release.
- Accept: in_valid & in_ready at a rising edge. Deliver: out_valid & out_ready at a rising edge.
- in_ready = (FSM==IDLE) & (!out_valid | out_ready). Accept and deliver in the same edge are allowed, giving full throughput.
- Single-cycle ops: result, flags and out_valid are registered at the accepting edge (latency 1).
- While out_valid=1 & out_ready=0, result, flags and out_err hold stable.
- Op codes:
  - 000 ADD: a+b.
  - 001 NEG: ~b+1.
  - 010 AND.
  - 011 XOR.
  - 100 SLL by b[SHW-1:0].
  - 101 SRL by b[SHW-1:0].
  - 110 SRA by b[SHW-1:0].
  - 111 MUL.
  - Shift ops ignore the upper bits of b.
- Flags:
  - zero = (result==0).
  - neg = result[WIDTH-1].
  - carry:
    - ADD: carry out of bit WIDTH-1.
    - NEG: 1 iff b==0.
    - Shifts: last bit shifted out; 0 when amount is 0.
    - AND/XOR: 0.
  - ovf:
    - ADD: signed overflow, i.e. operand signs equal and result sign different.
    - NEG: 1 iff b==100..0.
    - All other ops: 0.
- FSM states IDLE, MUL, DONE; only MUL uses MUL/DONE.
  - IDLE->MUL on accept of op 111 (MUL_EN only).
  - MUL->DONE after WIDTH iterations.
  - DONE->IDLE once out_valid is registered, which is on the same edge.
- rst_n low during MUL aborts: counter and partial product cleared, out_valid=0.
- in_valid is ignored while in_ready=0. Upstream must hold inputs stable; no internal operand capture beyond the accepting edge.

Optional Feature:
- Macro: ALU_PIPE_MUL_EN.
- Defined:
  - op 111 = unsigned shift-add multiply, one bit per cycle.
  - out_valid rises WIDTH+1 edges after accept; in_ready=0 throughout.
  - result = low WIDTH bits of the product.
  - carry = 1 iff the high WIDTH bits are nonzero; ovf=0.
- Undefined:
  - op 111 completes in 1 cycle with result=0, flags=0001, out_err=1.
  - FSM reduces to IDLE only.
- out_err=0 for all other ops in both builds.

Decomposition:
- Package alu_pipe_pkg:
  - op-code localparams/enum (OP_ADD..OP_MUL).
  - flag bit indices (FLG_ZERO=0, FLG_NEG=1, FLG_CARRY=2, FLG_OVF=3).
  - FSM state enum.
- Sub-module alu_mul_iter:
  - Iterative multiplier with start/done, counter and accumulator.
  - Instantiated only under ALU_PIPE_MUL_EN.
- Combinational op decode/flag logic stays in alu_pipe.

Test Plan:
- ADD a=0xFFFFFFFE, b=0xFFFFFFFC, out_ready=1 -> next cycle result=0xFFFFFFFA, flags carry=1, neg=1, ovf=0, zero=0. Then a=0x7FFFFFFF, b=1 -> result 0x80000000, ovf=1.
- NEG b=1 -> 0xFFFFFFFF, neg=1. NEG b=0 -> 0, zero=1, carry=1. SRA a=0xFFFFFF00, b=2 -> 0xFFFFFFC0. SRL a=0x80000001, b=1 -> 0x40000000, carry=1.
- Backpressure:
  - Stimulus: issue XOR 3^7 with out_ready=0 for 3 cycles, with a second op (AND 2&7) pending.
  - Required: result=4 held stable, in_ready=0.
  - On out_ready=1: 4 delivered and AND accepted on the same edge; next result=2.
- Back-to-back: 8 ADDs with in_valid=out_ready=1 -> one result per cycle, no bubbles, in order.
- MUL_EN build:
  - 7*9 -> result=63 exactly WIDTH+1 edges after accept, in_ready=0 meanwhile.
  - 0x10000*0x10000 -> result=0, carry=1, zero=1.
  - Non-MUL_EN build: op 111 -> out_err=1, result=0.
- Reset: assert rst_n=0 mid-MUL (cycle 5) -> out_valid=0 immediately. After release, ADD 1+0 -> result=1 with no stale MUL output.
